// File: rtl/attn_score_packer.sv
// Scalar-to-vector packer feeding the softmax stage: scales raw scores by 2^-shift
// with rounding, saturates to OUT_W bits and packs LANES elements per vector using
// two ping-pong buffers so input can keep streaming while a vector waits downstream.
module attn_score_packer #(
  parameter int unsigned LANES = 8,
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               cfg_shift,
  input  logic [IN_W-1:0]          score_in,
  input  logic                     score_last,
  input  logic                     score_valid,
  output logic                     score_ready,
  output logic [LANES*OUT_W-1:0]   vec_out,
  output logic                     vec_last,
  output logic                     vec_sat,
  output logic                     vec_valid,
  input  logic                     vec_ready
);

  localparam int unsigned LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned SUM_W   = IN_W + 1;
  localparam int unsigned SHIFT_W = 5;
  localparam logic [OUT_W-1:0] PAD     = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } buf_state_e;

  buf_state_e          buf_state_q [2];
  buf_state_e          buf_state_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [LANE_W-1:0]   lane_q, lane_d;

  logic [OUT_W-1:0]    buf_data_q  [2][LANES];
  logic [SHIFT_W-1:0]  buf_shift_q [2];
  logic                buf_sat_q   [2];
  logic                buf_last_q  [2];

  logic                in_fire;
  logic                out_fire;
  logic                close_vec;

  logic [SHIFT_W-1:0]      eff_shift;
  logic [SUM_W-1:0]        round_add;
  logic [SUM_W-1:0]        sum;
  logic signed [SUM_W-1:0] scaled;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [OUT_W-1:0]        elem;
  logic                    elem_sat;

  assign in_fire   = score_valid && score_ready;
  assign out_fire  = vec_valid && vec_ready;
  assign close_vec = in_fire && (score_last || (lane_q == LANE_W'(LANES - 1)));

  // Round-half-up shift and saturation of the incoming element
  always_comb begin
    eff_shift = (lane_q == '0) ? cfg_shift : buf_shift_q[wr_ptr_q];
    round_add = '0;
    if (eff_shift != '0) begin
      round_add = SUM_W'(1) << (eff_shift - SHIFT_W'(1));
    end
    sum      = {score_in[IN_W-1], score_in} + round_add;
    scaled   = $signed(sum) >>> eff_shift;
    sat_hi   = !scaled[SUM_W-1] && (|scaled[SUM_W-2:OUT_W-1]);
    sat_lo   = scaled[SUM_W-1] && !(&scaled[SUM_W-2:OUT_W-1]);
    elem_sat = sat_hi || sat_lo;
    elem     = scaled[OUT_W-1:0];
    if (sat_hi) begin
      elem = SAT_MAX;
    end else if (sat_lo) begin
      elem = SAT_MIN;
    end
  end

  // Next-state logic for both buffer FSMs, pointers and lane counter
  always_comb begin
    buf_state_d = buf_state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    lane_d      = lane_q;
    if (in_fire) begin
      if (buf_state_q[wr_ptr_q] == ST_EMPTY) begin
        buf_state_d[wr_ptr_q] = ST_FILLING;
      end
      if (close_vec) begin
        buf_state_d[wr_ptr_q] = ST_FULL;
        wr_ptr_d              = ~wr_ptr_q;
        lane_d                = '0;
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
    // The read buffer is FULL, the write buffer is not, so these never collide
    if (out_fire) begin
      buf_state_d[rd_ptr_q] = ST_EMPTY;
      rd_ptr_d              = ~rd_ptr_q;
    end
  end

  // State, pointer and input-ready registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_state_q[0] <= ST_EMPTY;
      buf_state_q[1] <= ST_EMPTY;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      lane_q         <= '0;
      score_ready    <= 1'b0;
    end else begin
      buf_state_q <= buf_state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lane_q      <= lane_d;
      score_ready <= (buf_state_d[wr_ptr_d] != ST_FULL);
    end
  end

  // Buffer payload: element write, row padding, shift latch and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int l = 0; l < LANES; l++) begin
          buf_data_q[b][l] <= '0;
        end
        buf_shift_q[b] <= '0;
        buf_sat_q[b]   <= 1'b0;
        buf_last_q[b]  <= 1'b0;
      end
    end else if (in_fire) begin
      buf_data_q[wr_ptr_q][lane_q] <= elem;
      if (score_last) begin
        for (int l = 0; l < LANES; l++) begin
          if (l > int'(lane_q)) begin
            buf_data_q[wr_ptr_q][l] <= PAD;
          end
        end
      end
      if (lane_q == '0) begin
        buf_shift_q[wr_ptr_q] <= cfg_shift;
        buf_sat_q[wr_ptr_q]   <= elem_sat;
      end else begin
        buf_sat_q[wr_ptr_q]   <= buf_sat_q[wr_ptr_q] | elem_sat;
      end
      if (close_vec) begin
        buf_last_q[wr_ptr_q] <= score_last;
      end
    end
  end

  // Output side reads straight from the read buffer registers
  always_comb begin
    vec_out = '0;
    for (int l = 0; l < LANES; l++) begin
      vec_out[l*OUT_W +: OUT_W] = buf_data_q[rd_ptr_q][l];
    end
    vec_valid = (buf_state_q[rd_ptr_q] == ST_FULL);
    vec_last  = buf_last_q[rd_ptr_q];
    vec_sat   = buf_sat_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_attn_score_packer.sv
// Self-checking bench for attn_score_packer: directed scenarios plus randomized
// traffic, checked against an arithmetic reference model with an expected-vector queue.
module tb_attn_score_packer;

  localparam int LANES = 8;
  localparam int OUT_W = 16;
  localparam int VW    = LANES * OUT_W;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    cfg_shift;
  logic [31:0]   score_in;
  logic          score_last;
  logic          score_valid;
  logic          score_ready;
  logic [VW-1:0] vec_out;
  logic          vec_last;
  logic          vec_sat;
  logic          vec_valid;
  logic          vec_ready;

  attn_score_packer dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_shift  (cfg_shift),
    .score_in   (score_in),
    .score_last (score_last),
    .score_valid(score_valid),
    .score_ready(score_ready),
    .vec_out    (vec_out),
    .vec_last   (vec_last),
    .vec_sat    (vec_sat),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] v;
    bit            l;
    bit            s;
  } exp_t;

  exp_t          expq[$];
  exp_t          head;
  int            checks = 0;
  int            errors = 0;
  int            out_count = 0;
  bit            rdy_rand = 0;

  int            cur_lane = 0;
  int            cur_shift = 0;
  logic [VW-1:0] cur_vec;
  bit            cur_sat;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // floor((x + 2^(s-1)) / 2^s), clamped to the OUT_W signed range
  function automatic logic [15:0] ref_scale(input longint x, input int s, output bit sat);
    longint d, num, q;
    if (s == 0) begin
      q = x;
    end else begin
      d   = longint'(1) << s;
      num = x + d / 2;
      q   = num / d;
      if ((num % d) != 0 && num < 0) q = q - 1;
    end
    sat = 0;
    if (q > 32767) begin
      q = 32767; sat = 1;
    end else if (q < -32768) begin
      q = -32768; sat = 1;
    end
    return 16'(q);
  endfunction

  task automatic model_accept(input logic [31:0] x, input bit last, input logic [4:0] sh);
    logic [15:0] v;
    bit          s;
    if (cur_lane == 0) begin
      cur_shift = int'(sh);
      for (int i = 0; i < LANES; i++) cur_vec[i*OUT_W +: OUT_W] = 16'h8000;
      cur_sat = 0;
    end
    v = ref_scale(longint'($signed(x)), cur_shift, s);
    cur_vec[cur_lane*OUT_W +: OUT_W] = v;
    cur_sat = cur_sat | s;
    if (last || cur_lane == LANES - 1) begin
      expq.push_back('{v: cur_vec, l: last, s: cur_sat});
      cur_lane = 0;
    end else begin
      cur_lane++;
    end
  endtask

  task automatic model_reset();
    expq.delete();
    cur_lane = 0;
  endtask

  // Output and input observation, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (vec_valid) begin
        check("vec_expected", 160'(expq.size() != 0), 160'(1));
        if (expq.size() != 0) begin
          head = expq[0];
          check("vec_out", 160'(vec_out), 160'(head.v));
          check("vec_last", 160'(vec_last), 160'(head.l));
          check("vec_sat", 160'(vec_sat), 160'(head.s));
          if (vec_ready) begin
            void'(expq.pop_front());
            out_count++;
          end
        end
      end
      if (score_valid && score_ready) model_accept(score_in, score_last, cfg_shift);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) vec_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input bit last, input logic [4:0] sh, output int waits);
    bit acc;
    acc = 0;
    waits = 0;
    score_in = x; score_last = last; cfg_shift = sh; score_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      acc = score_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
    end
    if (!acc) check("send_timeout", 160'(acc), 160'(1));
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 600; t++) begin
      if (expq.size() == 0 && !vec_valid) break;
      tick();
    end
    check("drain_queue", 160'(expq.size()), 160'(0));
    check("drain_valid", 160'(vec_valid), 160'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int            w, wsum, base, idx, tmp;
    logic [VW-1:0] ev;
    logic [31:0]   x;
    logic [4:0]    sh;
    int            vals3[8];

    rst = 1'b1; vec_ready = 1'b0; cfg_shift = '0; score_in = '0;
    score_last = 1'b0; score_valid = 1'b0;

    // Reset held during traffic
    for (int i = 0; i < 5; i++) begin
      score_valid = 1'b1; score_in = $urandom; score_last = 1'($urandom_range(0, 1));
      vec_ready = 1'b1;
      tick();
    end
    @(negedge clk);
    check("rst_vec_valid", 160'(vec_valid), 160'(0));
    check("rst_score_ready", 160'(score_ready), 160'(0));
    check("rst_vec_out", 160'(vec_out), 160'(0));
    check("rst_vec_flags", 160'({vec_last, vec_sat}), 160'(0));
    @(posedge clk); #1;
    score_valid = 1'b0; score_last = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_edge", 160'(score_ready), 160'(0));
    check("valid_after_rst", 160'(vec_valid), 160'(0));
    tick();
    check("ready_after_edge", 160'(score_ready), 160'(1));

    // Full vector, shift 0, scores 0..7 with last on the 8th
    vec_ready = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      send(32'(i), i == LANES - 1, 5'd0, w);
      if (i == LANES - 2) check("t2_not_yet_valid", 160'(vec_valid), 160'(0));
    end
    for (int i = 0; i < LANES; i++) ev[i*OUT_W +: OUT_W] = 16'(i);
    check("t2_valid", 160'(vec_valid), 160'(1));
    check("t2_vec", 160'(vec_out), 160'(ev));
    check("t2_flags", 160'({vec_last, vec_sat}), 160'(2'b10));
    drain();

    // Rounding and saturation with padding, shift 2
    send(32'd5, 0, 5'd2, w);
    send(32'd6, 0, 5'd2, w);
    send(-32'sd6, 0, 5'd2, w);
    send(32'd200000, 0, 5'd2, w);
    send(-32'sd200000, 1, 5'd2, w);
    vals3 = '{1, 2, -1, 32767, -32768, -32768, -32768, -32768};
    for (int i = 0; i < LANES; i++) ev[i*OUT_W +: OUT_W] = 16'(vals3[i]);
    check("t3_valid", 160'(vec_valid), 160'(1));
    check("t3_vec", 160'(vec_out), 160'(ev));
    check("t3_flags", 160'({vec_last, vec_sat}), 160'(2'b11));
    drain();

    // Backpressure: 20 offered, 16 fit
    vec_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      score_in = 32'(1000 + idx); score_last = 1'b0; cfg_shift = 5'd0;
      score_valid = (idx < 20);
      @(negedge clk);
      if (score_valid && score_ready) idx++;
      @(posedge clk); #1;
    end
    score_valid = 1'b0;
    check("bp_accepted", 160'(idx), 160'(16));
    check("bp_ready_low", 160'(score_ready), 160'(0));
    check("bp_valid_held", 160'(vec_valid), 160'(1));
    for (int i = 0; i < LANES; i++) ev[i*OUT_W +: OUT_W] = 16'(1000 + i);
    check("bp_vec_held", 160'(vec_out), 160'(ev));
    vec_ready = 1'b1;
    for (int i = 16; i < 24; i++) send(32'(1000 + i), i == 23, 5'd0, w);
    drain();

    // Continuous streaming with last every 8th element
    base = out_count; wsum = 0;
    for (int i = 0; i < 64; i++) begin
      send(32'(i * 37 - 500), (i % 8) == 7, 5'd3, w);
      wsum += w;
    end
    check("stream_no_stall", 160'(wsum), 160'(0));
    drain();
    check("stream_vec_count", 160'(out_count - base), 160'(8));

    // Shift changes mid-vector: sampled only on lane 0
    send(32'd40, 0, 5'd1, w);
    for (int i = 1; i < LANES; i++) send(32'd40, 0, 5'd4, w);
    for (int i = 0; i < LANES; i++) ev[i*OUT_W +: OUT_W] = 16'd20;
    check("t6_vec_a", 160'(vec_out), 160'(ev));
    check("t6_last_a", 160'(vec_last), 160'(0));
    send(32'd40, 1, 5'd4, w);
    for (int i = 0; i < LANES; i++) ev[i*OUT_W +: OUT_W] = 16'h8000;
    ev[0 +: OUT_W] = 16'd3;
    check("t6_vec_b", 160'(vec_out), 160'(ev));
    check("t6_last_b", 160'(vec_last), 160'(1));
    drain();

    // Reset mid-handoff: buffered data must vanish
    vec_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(32'(77 + i), 0, 5'd0, w);
    rst = 1'b1;
    model_reset();
    tick(); tick();
    @(negedge clk);
    check("rst2_vec_valid", 160'(vec_valid), 160'(0));
    check("rst2_score_ready", 160'(score_ready), 160'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    vec_ready = 1'b1;
    base = out_count;
    for (int i = 0; i < 20; i++) tick();
    check("rst2_no_stale", 160'(out_count - base), 160'(0));
    check("rst2_ready", 160'(score_ready), 160'(1));

    // Randomized traffic with random downstream backpressure
    rdy_rand = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) tick();
      case ($urandom_range(0, 3))
        0: begin tmp = int'($urandom_range(0, 200)) - 100; x = 32'(tmp); end
        1: x = $urandom;
        2: begin tmp = int'($urandom_range(0, 262143)) - 131072; x = 32'(tmp); end
        default: x = ($urandom_range(0, 1) != 0) ? 32'h7fffffff : 32'h80000000;
      endcase
      if ($urandom_range(0, 1) != 0) sh = 5'($urandom_range(0, 4));
      else sh = 5'($urandom_range(0, 31));
      send(x, $urandom_range(0, 5) == 0, sh, w);
    end
    // Close any partial row
    send(32'd1, 1, 5'd0, w);
    rdy_rand = 0;
    @(posedge clk); #1;
    vec_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
